// File: rtl/mem_port_arbiter_if.sv
// Bundle of fetch, data and RAM-side signals for the unified-memory arbiter.
// slave is the arbiter's view; master is the core plus RAM side.
interface mem_port_arbiter_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  i_req;
    logic [31:0]           i_addr;
    logic                  i_gnt;
    logic                  i_rvalid;
    logic [DATA_WIDTH-1:0] i_rdata;

    logic                  d_req;
    logic                  d_wen;
    logic [31:0]           d_addr;
    logic [DATA_WIDTH-1:0] d_wdata;
    logic                  d_gnt;
    logic                  d_rvalid;
    logic [DATA_WIDTH-1:0] d_rdata;

    logic                  ram_en;
    logic                  ram_we;
    logic [31:0]           ram_addr;
    logic [DATA_WIDTH-1:0] ram_din;
    logic [DATA_WIDTH-1:0] ram_dout;

    modport slave (
        input  i_req, i_addr,
        output i_gnt, i_rvalid, i_rdata,
        input  d_req, d_wen, d_addr, d_wdata,
        output d_gnt, d_rvalid, d_rdata,
        output ram_en, ram_we, ram_addr, ram_din,
        input  ram_dout
    );

    modport master (
        output i_req, i_addr,
        input  i_gnt, i_rvalid, i_rdata,
        output d_req, d_wen, d_addr, d_wdata,
        input  d_gnt, d_rvalid, d_rdata,
        input  ram_en, ram_we, ram_addr, ram_din,
        output ram_dout
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous RAM between fetch and data ports.
// Data wins ties; a starvation counter forces a fetch grant periodically.
module mem_port_arbiter #(
    parameter int DATA_WIDTH   = 32,
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_WIDTH    = 3
) (
    input logic               clk,
    input logic               rst,
    mem_port_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_INST,
        OWN_DATA
    } owner_e;

    localparam logic [CNT_WIDTH-1:0] LIMIT = CNT_WIDTH'(STARVE_LIMIT);

    logic [CNT_WIDTH-1:0]  starve_q, starve_d;
    owner_e                owner_q, owner_d;
    logic                  i_rvalid_q, d_rvalid_q;
    logic [DATA_WIDTH-1:0] i_hold_q, d_hold_q;

    logic force_i;
    logic i_gnt, d_gnt;
    logic unused_addr_lsbs;

    // Grants are gated by reset so nothing reaches the RAM while held.
    always_comb begin
        force_i = (starve_q == LIMIT);
        d_gnt   = rst & bus.d_req & ~(bus.i_req & force_i);
        i_gnt   = rst & bus.i_req & ~d_gnt;
    end

    always_comb begin
        starve_d = '0;
        if (bus.i_req && !i_gnt) begin
            starve_d = (starve_q == LIMIT) ? starve_q : starve_q + 1'b1;
        end
    end

    always_comb begin
        owner_d = OWN_NONE;
        unique case (1'b1)
            i_gnt:              owner_d = OWN_INST;
            d_gnt & ~bus.d_wen: owner_d = OWN_DATA;
            default:            owner_d = OWN_NONE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve_q   <= '0;
            owner_q    <= OWN_NONE;
            i_rvalid_q <= 1'b0;
            d_rvalid_q <= 1'b0;
            i_hold_q   <= '0;
            d_hold_q   <= '0;
        end else begin
            starve_q   <= starve_d;
            owner_q    <= owner_d;
            i_rvalid_q <= (owner_d == OWN_INST);
            d_rvalid_q <= (owner_d == OWN_DATA);
            if (owner_q == OWN_INST) begin
                i_hold_q <= bus.ram_dout;
            end
            if (owner_q == OWN_DATA) begin
                d_hold_q <= bus.ram_dout;
            end
        end
    end

    always_comb begin
        bus.ram_en   = i_gnt | d_gnt;
        bus.ram_we   = d_gnt & bus.d_wen;
        bus.ram_addr = '0;
        bus.ram_din  = '0;
        if (d_gnt) begin
            bus.ram_addr = {2'b00, bus.d_addr[31:2]};
            bus.ram_din  = bus.d_wdata;
        end else if (i_gnt) begin
            bus.ram_addr = {2'b00, bus.i_addr[31:2]};
        end
    end

    assign bus.i_gnt    = i_gnt;
    assign bus.d_gnt    = d_gnt;
    assign bus.i_rvalid = i_rvalid_q;
    assign bus.d_rvalid = d_rvalid_q;
    assign bus.i_rdata  = i_rvalid_q ? bus.ram_dout : i_hold_q;
    assign bus.d_rdata  = d_rvalid_q ? bus.ram_dout : d_hold_q;

    // Word accesses only: byte offset bits are dropped.
    assign unused_addr_lsbs = ^{bus.i_addr[1:0], bus.d_addr[1:0]};
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus a randomized run
// against a transaction-level model of grants, memory and read returns.
module tb_mem_port_arbiter;
    localparam int DW  = 32;
    localparam int LIM = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.DATA_WIDTH(DW)) bus ();

    mem_port_arbiter #(
        .DATA_WIDTH  (DW),
        .STARVE_LIMIT(LIM),
        .CNT_WIDTH   (3)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    logic [31:0] ram [64];
    always @(posedge clk) begin
        if (bus.ram_en) begin
            if (bus.ram_we) ram[bus.ram_addr[5:0]] <= bus.ram_din;
            else bus.ram_dout <= ram[bus.ram_addr[5:0]];
        end
    end

    int total = 0;
    int bad = 0;

    logic [31:0] ref_mem [64];
    int          lost;
    logic        pend_i, pend_d;
    logic [31:0] pi_val, pd_val, hold_i, hold_d;
    logic        exp_ig, exp_dg, exp_irv, exp_drv;
    logic [31:0] exp_ird, exp_drd;

    task automatic model_reset();
        lost = 0;
        pend_i = 1'b0;
        pend_d = 1'b0;
        hold_i = '0;
        hold_d = '0;
    endtask

    task automatic model_eval();
        bit forced;
        forced  = (lost >= LIM);
        exp_dg  = bus.d_req && !(bus.i_req && forced);
        exp_ig  = bus.i_req && !exp_dg;
        exp_irv = pend_i;
        exp_drv = pend_d;
        exp_ird = pend_i ? pi_val : hold_i;
        exp_drd = pend_d ? pd_val : hold_d;
    endtask

    task automatic model_commit();
        if (pend_i) hold_i = pi_val;
        if (pend_d) hold_d = pd_val;
        pend_i = exp_ig;
        pi_val = ref_mem[bus.i_addr[7:2]];
        pend_d = exp_dg && !bus.d_wen;
        pd_val = ref_mem[bus.d_addr[7:2]];
        if (exp_dg && bus.d_wen) ref_mem[bus.d_addr[7:2]] = bus.d_wdata;
        if (bus.i_req && !exp_ig) lost = (lost < LIM) ? lost + 1 : LIM;
        else lost = 0;
    endtask

    task automatic settle();
        @(negedge clk);
        model_eval();
    endtask

    task automatic advance();
        model_commit();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic ir, input logic [31:0] ia,
                         input logic dr, input logic dw,
                         input logic [31:0] da, input logic [31:0] dd);
        bus.i_req   = ir;
        bus.i_addr  = ia;
        bus.d_req   = dr;
        bus.d_wen   = dw;
        bus.d_addr  = da;
        bus.d_wdata = dd;
    endtask

    task automatic idle(input int n);
        drive(0, 0, 0, 0, 0, 0);
        for (int k = 0; k < n; k++) begin
            settle();
            advance();
        end
    endtask

    task automatic test_reset();
        #1 rst = 1'b0;
        model_reset();
        drive(1, 32'h0, 1, 0, 32'h0, 32'h0);
        @(negedge clk);
        total++; if (bus.i_gnt !== 1'b0) begin bad++; $display("FAIL rst_i_gnt: got %b want 0", bus.i_gnt); end
        total++; if (bus.d_gnt !== 1'b0) begin bad++; $display("FAIL rst_d_gnt: got %b want 0", bus.d_gnt); end
        total++; if (bus.ram_en !== 1'b0) begin bad++; $display("FAIL rst_ram_en: got %b want 0", bus.ram_en); end
        total++; if (bus.ram_we !== 1'b0) begin bad++; $display("FAIL rst_ram_we: got %b want 0", bus.ram_we); end
        total++; if ({bus.i_rvalid, bus.d_rvalid} !== 2'b00) begin bad++; $display("FAIL rst_rvalid: got %b want 00", {bus.i_rvalid, bus.d_rvalid}); end
        total++; if (bus.i_rdata !== 32'h0) begin bad++; $display("FAIL rst_i_rdata: got %h want 0", bus.i_rdata); end
        total++; if (bus.d_rdata !== 32'h0) begin bad++; $display("FAIL rst_d_rdata: got %h want 0", bus.d_rdata); end
        @(posedge clk);
        #1 rst = 1'b1;
        settle();
        total++; if (bus.d_gnt !== 1'b1 || bus.i_gnt !== 1'b0) begin bad++; $display("FAIL rst_release_gnt: got d=%b i=%b want d=1 i=0", bus.d_gnt, bus.i_gnt); end
        advance();
        drive(0, 0, 0, 0, 0, 0);
        settle();
        total++; if (bus.d_rvalid !== 1'b1 || bus.d_rdata !== exp_drd) begin bad++; $display("FAIL rst_release_load: got %b/%h want 1/%h", bus.d_rvalid, bus.d_rdata, exp_drd); end
        advance();
        idle(2);
    endtask

    task automatic test_fetch();
        drive(1, 32'h0000_0010, 0, 0, 0, 0);
        settle();
        total++; if (bus.i_gnt !== 1'b1 || bus.d_gnt !== 1'b0) begin bad++; $display("FAIL fetch_gnt: got i=%b d=%b want i=1 d=0", bus.i_gnt, bus.d_gnt); end
        total++; if (bus.ram_addr !== 32'h4 || bus.ram_en !== 1'b1 || bus.ram_we !== 1'b0) begin bad++; $display("FAIL fetch_ram: got addr=%h en=%b we=%b want 4/1/0", bus.ram_addr, bus.ram_en, bus.ram_we); end
        advance();
        drive(0, 32'h0000_0010, 0, 0, 0, 0);
        settle();
        total++; if (bus.i_rvalid !== 1'b1 || bus.i_rdata !== ref_mem[4]) begin bad++; $display("FAIL fetch_data: got %b/%h want 1/%h", bus.i_rvalid, bus.i_rdata, ref_mem[4]); end
        advance();
        settle();
        total++; if (bus.i_rvalid !== 1'b0 || bus.i_rdata !== ref_mem[4]) begin bad++; $display("FAIL fetch_hold: got %b/%h want 0/%h", bus.i_rvalid, bus.i_rdata, ref_mem[4]); end
        advance();
    endtask

    task automatic test_store_load();
        drive(0, 0, 1, 1, 32'h20, 32'hDEAD_BEEF);
        settle();
        total++; if (bus.d_gnt !== 1'b1 || bus.ram_we !== 1'b1) begin bad++; $display("FAIL store_gnt: got gnt=%b we=%b want 1/1", bus.d_gnt, bus.ram_we); end
        total++; if (bus.ram_addr !== 32'h8 || bus.ram_din !== 32'hDEAD_BEEF) begin bad++; $display("FAIL store_ram: got %h/%h want 8/deadbeef", bus.ram_addr, bus.ram_din); end
        advance();
        drive(0, 0, 1, 0, 32'h20, 32'h0);
        settle();
        total++; if (bus.d_gnt !== 1'b1 || bus.ram_we !== 1'b0 || bus.d_rvalid !== 1'b0) begin bad++; $display("FAIL load_gnt: got gnt=%b we=%b rv=%b want 1/0/0", bus.d_gnt, bus.ram_we, bus.d_rvalid); end
        advance();
        drive(0, 0, 0, 0, 0, 0);
        settle();
        total++; if (bus.d_rvalid !== 1'b1 || bus.d_rdata !== 32'hDEAD_BEEF) begin bad++; $display("FAIL load_data: got %b/%h want 1/deadbeef", bus.d_rvalid, bus.d_rdata); end
        advance();
        settle();
        total++; if (bus.d_rvalid !== 1'b0 || bus.d_rdata !== 32'hDEAD_BEEF) begin bad++; $display("FAIL load_hold: got %b/%h want 0/deadbeef", bus.d_rvalid, bus.d_rdata); end
        advance();
    endtask

    task automatic test_starvation();
        drive(1, {24'h0, 8'($urandom_range(0, 255))}, 1, 0, {24'h0, 8'($urandom_range(0, 255))}, 0);
        for (int k = 0; k < 15; k++) begin
            bit want_i;
            want_i = (k % 5 == 4);
            settle();
            total++; if (bus.i_gnt !== want_i || bus.d_gnt !== !want_i) begin bad++; $display("FAIL starve_c%0d: got i=%b d=%b want i=%b", k, bus.i_gnt, bus.d_gnt, want_i); end
            total++; if (bus.i_rvalid !== exp_irv || bus.i_rdata !== exp_ird || bus.d_rvalid !== exp_drv || bus.d_rdata !== exp_drd) begin bad++; $display("FAIL starve_ret_c%0d: got %b/%h %b/%h want %b/%h %b/%h", k, bus.i_rvalid, bus.i_rdata, bus.d_rvalid, bus.d_rdata, exp_irv, exp_ird, exp_drv, exp_drd); end
            advance();
            if (want_i) bus.i_addr = {24'h0, 8'($urandom_range(0, 255))};
            bus.d_addr = {24'h0, 8'($urandom_range(0, 255))};
        end
        idle(2);
    endtask

    task automatic test_write_hides_fetch();
        drive(1, 32'h30, 1, 1, 32'h40, $urandom);
        settle();
        total++; if (bus.d_gnt !== 1'b1 || bus.i_gnt !== 1'b0 || bus.ram_we !== 1'b1) begin bad++; $display("FAIL hide_gnt: got d=%b i=%b we=%b want 1/0/1", bus.d_gnt, bus.i_gnt, bus.ram_we); end
        advance();
        bus.d_req = 1'b0;
        settle();
        total++; if (bus.i_rvalid !== 1'b0 || bus.d_rvalid !== 1'b0) begin bad++; $display("FAIL hide_norv: got i=%b d=%b want 0/0", bus.i_rvalid, bus.d_rvalid); end
        total++; if (bus.i_gnt !== 1'b1) begin bad++; $display("FAIL hide_fetch_gnt: got %b want 1", bus.i_gnt); end
        advance();
        drive(0, 0, 0, 0, 0, 0);
        settle();
        total++; if (bus.i_rvalid !== 1'b1 || bus.i_rdata !== ref_mem[12]) begin bad++; $display("FAIL hide_fetch_data: got %b/%h want 1/%h", bus.i_rvalid, bus.i_rdata, ref_mem[12]); end
        advance();
    endtask

    task automatic test_reset_mid_read();
        drive(1, 32'h10, 1, 0, 32'h20, 0);
        settle();
        total++; if (bus.d_gnt !== 1'b1) begin bad++; $display("FAIL midrst_gnt: got %b want 1", bus.d_gnt); end
        rst = 1'b0;
        model_reset();
        drive(0, 0, 0, 0, 0, 0);
        #1;
        total++; if (bus.i_rdata !== 32'h0 || bus.d_rdata !== 32'h0) begin bad++; $display("FAIL midrst_hold: got %h/%h want 0/0", bus.i_rdata, bus.d_rdata); end
        @(posedge clk);
        #1;
        @(posedge clk);
        #1 rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            settle();
            total++; if (bus.i_rvalid !== 1'b0 || bus.d_rvalid !== 1'b0 || bus.d_rdata !== 32'h0) begin bad++; $display("FAIL midrst_norv_c%0d: got %b %b %h want 0 0 0", k, bus.i_rvalid, bus.d_rvalid, bus.d_rdata); end
            advance();
        end
    endtask

    task automatic test_random();
        logic ia, da;
        ia = 1'b0;
        da = 1'b0;
        for (int c = 0; c < 400; c++) begin
            logic [31:0] ea;
            if (!ia && $urandom_range(0, 3) != 0) begin
                ia = 1'b1;
                bus.i_addr = {24'h0, 8'($urandom_range(0, 255))};
            end
            if (!da && $urandom_range(0, 3) != 0) begin
                da = 1'b1;
                bus.d_wen   = 1'($urandom_range(0, 1));
                bus.d_addr  = {24'h0, 8'($urandom_range(0, 255))};
                bus.d_wdata = $urandom;
            end
            bus.i_req = ia;
            bus.d_req = da;
            settle();
            ea = exp_dg ? (bus.d_addr >> 2) : (bus.i_addr >> 2);
            total++; if (bus.i_gnt !== exp_ig || bus.d_gnt !== exp_dg) begin bad++; $display("FAIL rnd_gnt_c%0d: got i=%b d=%b want i=%b d=%b", c, bus.i_gnt, bus.d_gnt, exp_ig, exp_dg); end
            total++; if (bus.ram_en !== (exp_ig | exp_dg) || bus.ram_we !== (exp_dg & bus.d_wen)) begin bad++; $display("FAIL rnd_ram_c%0d: got en=%b we=%b", c, bus.ram_en, bus.ram_we); end
            if (exp_ig | exp_dg) begin
                total++; if (bus.ram_addr !== ea) begin bad++; $display("FAIL rnd_addr_c%0d: got %h want %h", c, bus.ram_addr, ea); end
            end
            if (exp_dg && bus.d_wen) begin
                total++; if (bus.ram_din !== bus.d_wdata) begin bad++; $display("FAIL rnd_din_c%0d: got %h want %h", c, bus.ram_din, bus.d_wdata); end
            end
            total++; if (bus.i_rvalid !== exp_irv || bus.i_rdata !== exp_ird) begin bad++; $display("FAIL rnd_i_ret_c%0d: got %b/%h want %b/%h", c, bus.i_rvalid, bus.i_rdata, exp_irv, exp_ird); end
            total++; if (bus.d_rvalid !== exp_drv || bus.d_rdata !== exp_drd) begin bad++; $display("FAIL rnd_d_ret_c%0d: got %b/%h want %b/%h", c, bus.d_rvalid, bus.d_rdata, exp_drv, exp_drd); end
            if (exp_ig) ia = 1'b0;
            if (exp_dg) da = 1'b0;
            advance();
        end
        idle(2);
    endtask

    initial begin
        for (int k = 0; k < 64; k++) begin
            ram[k]     = 32'h1000_0000 + k * 32'h0001_0203;
            ref_mem[k] = 32'h1000_0000 + k * 32'h0001_0203;
        end
        bus.ram_dout = '0;
        drive(0, 0, 0, 0, 0, 0);
        model_reset();
        test_reset();
        test_fetch();
        test_store_load();
        test_starvation();
        test_write_hides_fetch();
        test_reset_mid_read();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
